// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int PORT_CORE = 0;
  localparam int PORT_DBG  = 1;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 32;
  localparam int DEF_BURST_MAX = 8;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin winner select; the pointer remembers the last port
// that started a burst so the other one wins the next tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_gnt;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end
  end

  // Reset to "port 1 last" so port 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (update) begin
      last_gnt <= gnt[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core LSU and the debug port,
// with locked bursts, a forced-release beat limit and registered responses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic              req_we_0,
  input  logic [31:0]       req_addr_0,
  input  logic [DATA_W-1:0] req_wdata_0,
  input  logic              req_last_0,
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic              req_we_1,
  input  logic [31:0]       req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_1,
  input  logic              req_last_1,
  output logic              rsp_valid_0,
  output logic [DATA_W-1:0] rsp_rdata_0,
  output logic              rsp_err_0,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_rdata_1,
  output logic              rsp_err_1,
  output logic [31:0]       AddrB,
  output logic [DATA_W-1:0] DataWrite,
  output logic              MemRW,
  input  logic [DATA_W-1:0] DataB
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  arb_state_e        state, state_next;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_next, beat_cnt_inc;
  logic [1:0]        valid, ready, acc, arb_gnt;
  logic              sel, any_acc, beat_end, burst_start, in_range, rd_ok;
  logic              sel_we, sel_last;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign valid = {req_valid_1, req_valid_0};

  rr_arb2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (valid),
    .update (burst_start),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  // Ready is held low throughout reset, not just after the first edge.
  always_comb begin
    ready = 2'b00;
    if (rst_n) begin
      case (state)
        IDLE:    ready = arb_gnt;
        OWN0:    ready = 2'b01;
        OWN1:    ready = 2'b10;
        default: ready = 2'b00;
      endcase
    end
  end

  assign acc         = ready & valid;
  assign any_acc     = |acc;
  assign sel         = ready[PORT_DBG];
  assign burst_start = any_acc && (state == IDLE);

  always_comb begin
    sel_we    = req_we_0;
    sel_last  = req_last_0;
    sel_addr  = req_addr_0;
    sel_wdata = req_wdata_0;
    if (sel) begin
      sel_we    = req_we_1;
      sel_last  = req_last_1;
      sel_addr  = req_addr_1;
      sel_wdata = req_wdata_1;
    end
  end

  assign in_range     = sel_addr < 32'(DEPTH);
  assign rd_ok        = !sel_we && in_range;
  assign beat_cnt_inc = beat_cnt + CNT_W'(1);
  // The beat that reaches the limit closes the burst as if it carried last.
  assign beat_end     = any_acc && (sel_last || (beat_cnt_inc == CNT_W'(BURST_MAX)));

  always_comb begin
    state_next    = state;
    beat_cnt_next = beat_cnt;
    if (any_acc) begin
      beat_cnt_next = beat_end ? '0 : beat_cnt_inc;
    end
    case (state)
      IDLE: begin
        if (any_acc && !beat_end) begin
          state_next = sel ? OWN1 : OWN0;
        end
      end
      OWN0, OWN1: begin
        if (beat_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready_0 = ready[PORT_CORE];
  assign req_ready_1 = ready[PORT_DBG];
  assign AddrB       = any_acc ? sel_addr : 32'd0;
  assign DataWrite   = any_acc ? sel_wdata : '0;
  assign MemRW       = any_acc && sel_we && in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_0 <= 1'b0;
      rsp_rdata_0 <= '0;
      rsp_err_0   <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_rdata_1 <= '0;
      rsp_err_1   <= 1'b0;
    end else begin
      rsp_valid_0 <= acc[PORT_CORE];
      rsp_err_0   <= acc[PORT_CORE] && !in_range;
      rsp_rdata_0 <= (acc[PORT_CORE] && rd_ok) ? DataB : '0;
      rsp_valid_1 <= acc[PORT_DBG];
      rsp_err_1   <= acc[PORT_DBG] && !in_range;
      rsp_rdata_1 <= (acc[PORT_DBG] && rd_ok) ? DataB : '0;
    end
  end

endmodule
